// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter: programmable modulus, parallel load, wrap or saturate mode,
// terminal count and overflow/underflow pulses. Optional wrap-event counter under UDCNT_WRAP_CNT_EN.
module up_down_counter_param #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = (2**WIDTH) - 1,
    parameter int unsigned RST_VAL = 0,
    parameter int unsigned WRAPW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             ovf,
    output logic             unf
`ifdef UDCNT_WRAP_CNT_EN
   ,output logic [WRAPW-1:0] wrap_cnt
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    // Reject parameter sets the counter cannot represent.
    if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1 || RST_VAL > MAX_VAL || WRAPW < 1)
    begin : g_param_check
        $error("up_down_counter_param: illegal parameter combination");
    end

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_max, at_zero;

    assign at_max  = (dout_q == MAX_V);
    assign at_zero = (dout_q == '0);

    // Next count: load beats count; the modulus is applied by comparison, never by natural rollover.
    always_comb begin
        dout_d = dout_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (load) begin
            dout_d = (din > MAX_V) ? MAX_V : din;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    ovf_d  = 1'b1;
                    dout_d = sat ? MAX_V : '0;
                end else begin
                    dout_d = dout_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    unf_d  = 1'b1;
                    dout_d = sat ? '0 : MAX_V;
                end else begin
                    dout_d = dout_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= RST_V;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign dout = dout_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;
    // Predicts the boundary event the next edge will report.
    assign tc   = en & ~load & (up ? at_max : at_zero);

`ifdef UDCNT_WRAP_CNT_EN
    logic [WRAPW-1:0] wrap_q, wrap_d;

    // Advances together with the pulse register so the new count and the pulse appear together.
    always_comb begin
        wrap_d = wrap_q;
        if (ovf_d || unf_d) begin
            wrap_d = wrap_q + WRAPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_up_down_counter_param.sv
// Randomised self-checking bench for up_down_counter_param against a modular-arithmetic reference model.
module tb_up_down_counter_param;

    localparam int W     = 4;
    localparam int MAXV  = 9;
    localparam int RSTV  = 0;
    localparam int WRAPW = 2;

    logic         clk = 1'b0;
    logic         rst, en, up, load, sat;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         tc, ovf, unf;
`ifdef UDCNT_WRAP_CNT_EN
    logic [WRAPW-1:0] wrap_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int m_cnt  = RSTV;
    int m_wrap = 0;
    int m_ovf  = 0;
    int m_unf  = 0;

    always #5 clk = ~clk;

    up_down_counter_param #(
        .WIDTH  (W),
        .MAX_VAL(MAXV),
        .RST_VAL(RSTV),
        .WRAPW  (WRAPW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .up  (up),
        .load(load),
        .din (din),
        .sat (sat),
        .dout(dout),
        .tc  (tc),
        .ovf (ovf),
        .unf (unf)
`ifdef UDCNT_WRAP_CNT_EN
       ,.wrap_cnt(wrap_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts modulo MAXV+1, saturating at the boundaries when asked.
    task automatic model_edge(input bit r, input bit l, input bit e, input bit u, input bit s, input int d);
        m_ovf = 0;
        m_unf = 0;
        if (r) begin
            m_cnt  = RSTV;
            m_wrap = 0;
        end else if (l) begin
            m_cnt = (d > MAXV) ? MAXV : d;
        end else if (e) begin
            if (u) begin
                m_ovf = (m_cnt == MAXV) ? 1 : 0;
                if (!(m_ovf == 1 && s)) m_cnt = (m_cnt + 1) % (MAXV + 1);
            end else begin
                m_unf = (m_cnt == 0) ? 1 : 0;
                if (!(m_unf == 1 && s)) m_cnt = (m_cnt + MAXV) % (MAXV + 1);
            end
        end
        if (m_ovf == 1 || m_unf == 1) m_wrap = (m_wrap + 1) % (1 << WRAPW);
    endtask

    // One clock: drive on the falling edge, check tc, then check registered outputs after the rising edge.
    task automatic step(input bit r, input bit l, input bit e, input bit u, input bit s, input int d);
        int exp_tc;
        @(negedge clk);
        rst  = r;
        load = l;
        en   = e;
        up   = u;
        sat  = s;
        din  = W'(d);
        #1;
        exp_tc = (e && !l && (u ? (m_cnt == MAXV) : (m_cnt == 0))) ? 1 : 0;
        check_eq("tc", 32'(tc), 32'(exp_tc));
        @(posedge clk);
        model_edge(r, l, e, u, s, d);
        #1;
        check_eq("dout", 32'(dout), 32'(m_cnt));
        check_eq("ovf", 32'(ovf), 32'(m_ovf));
        check_eq("unf", 32'(unf), 32'(m_unf));
`ifdef UDCNT_WRAP_CNT_EN
        check_eq("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
`endif
    endtask

    initial begin
        int exp1[12];
        int exp2[5];
        rst  = 1'b1;
        load = 1'b0;
        en   = 1'b0;
        up   = 1'b0;
        sat  = 1'b0;
        din  = '0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_eq("reset_dout", 32'(dout), 32'(RSTV));
        check_eq("reset_ovf", 32'(ovf), 0);

        // Count up through the 9->0 wrap.
        exp1 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1, 0, 0);
            check_eq("t1_dout", 32'(dout), 32'(exp1[i]));
            check_eq("t1_ovf", 32'(ovf), (i == 9) ? 32'd1 : 32'd0);
        end

        // Load 3 then count down through the 0->9 wrap.
        step(0, 1, 0, 0, 0, 3);
        check_eq("t2_load", 32'(dout), 32'd3);
        exp2 = '{2, 1, 0, 9, 8};
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 0);
            check_eq("t2_dout", 32'(dout), 32'(exp2[i]));
            check_eq("t2_unf", 32'(unf), (i == 3) ? 32'd1 : 32'd0);
        end

        // Saturate at MAX: repeated ovf, then step down.
        step(0, 1, 0, 0, 1, 8);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, 1, 0);
            check_eq("t3_dout", 32'(dout), 32'd9);
            check_eq("t3_ovf", 32'(ovf), (i == 0) ? 32'd0 : 32'd1);
        end
        step(0, 0, 1, 0, 1, 0);
        check_eq("t3_down", 32'(dout), 32'd8);

        // Load clamp and load-over-count priority.
        step(0, 1, 0, 0, 0, 15);
        check_eq("t4_clamp", 32'(dout), 32'd9);
        step(0, 1, 1, 1, 0, 5);
        check_eq("t4_prio", 32'(dout), 32'd5);

        // Reset while an overflow is pending, then hold.
        step(0, 1, 0, 0, 0, 9);
        step(1, 0, 1, 1, 0, 0);
        check_eq("t5_rst_dout", 32'(dout), 32'd0);
        check_eq("t5_rst_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 0);
            check_eq("t5_hold", 32'(dout), 32'd0);
        end

        // Wrap-event counting across several wraps with a load in between.
        step(0, 1, 0, 0, 0, 9);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 0, 0);
            if (i == 2) step(0, 1, 0, 0, 0, 9);
            else        step(0, 1, 0, 0, 0, 9);
        end
        step(1, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(39) == 0),
                 ($urandom_range(7) == 0),
                 ($urandom_range(3) != 0),
                 1'($urandom),
                 1'($urandom),
                 int'($urandom_range(15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
